// File: rtl/operand_fetch_if.sv
// Operand-fetch stage bus: upstream instruction handshake, write-back port, ALU-side handshake.
interface operand_fetch_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AW   = 5;
    localparam int unsigned FW   = 3;
    localparam int unsigned IMMW = 16;

    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [FW-1:0]    func;
    logic             use_imm;
    logic [IMMW-1:0]  imm;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [FW-1:0]    f;

    modport master (
        output in_valid, ra1, ra2, func, use_imm, imm, we, wa, wd, out_ready,
        input  in_ready, out_valid, a, b, f
    );

    modport slave (
        input  in_valid, ra1, ra2, func, use_imm, imm, we, wa, wd, out_ready,
        output in_ready, out_valid, a, b, f
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: 32-entry register file feeding a one-deep registered ALU operand stage.
// Optional WB_BYPASS_EN forwards same-cycle write-back data into the loaded operands.
module operand_fetch #(
    parameter int unsigned WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    operand_fetch_if.slave bus
);
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned FW    = 3;
    localparam int unsigned IMMW  = 16;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             load_c;
    logic             in_ready_c;
    logic [WIDTH-1:0] regs [NREGS];
    logic [WIDTH-1:0] rd1_c;
    logic [WIDTH-1:0] rd2_c;
    logic [WIDTH-1:0] imm_ext_c;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [FW-1:0]    f_q;

    // Stage can take a new op when empty or when the held op leaves this cycle
    assign in_ready_c    = (state_q == EMPTY) || bus.out_ready;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == FULL);
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.f         = f_q;

    // Register file; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (bus.we && (bus.wa != AW'(0))) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    assign imm_ext_c = {{(WIDTH - IMMW){bus.imm[IMMW-1]}}, bus.imm};

    always_comb begin
        rd1_c = (bus.ra1 == AW'(0)) ? '0 : regs[bus.ra1];
        rd2_c = (bus.ra2 == AW'(0)) ? '0 : regs[bus.ra2];
`ifdef WB_BYPASS_EN
        if (bus.we && (bus.wa != AW'(0)) && (bus.wa == bus.ra1)) begin
            rd1_c = bus.wd;
        end
        if (bus.we && (bus.wa != AW'(0)) && (bus.wa == bus.ra2)) begin
            rd2_c = bus.wd;
        end
`else
        // Reads see the pre-write value; the write lands at the same edge
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        if (bus.in_valid && in_ready_c) begin
            load_c = 1'b1;
        end
        case (state_q)
            EMPTY: begin
                if (load_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load_c) begin
                    state_d = FULL;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
        endcase
    end

    // Operand registers only change on accept, so a stalled op is immune to later writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            f_q <= '0;
        end else if (load_c) begin
            a_q <= rd1_c;
            b_q <= bus.use_imm ? imm_ext_c : rd2_c;
            f_q <= bus.func;
        end
    end
endmodule
